// File: rtl/lsu.sv
// Load/store unit: accepts one byte/half/word load or store from the LSB, runs it
// against the memory controller, and broadcasts extended load results on the CDB.
module lsu #(
  parameter logic [5:0] LB  = 6'd11,
  parameter logic [5:0] LH  = 6'd12,
  parameter logic [5:0] LW  = 6'd13,
  parameter logic [5:0] LBU = 6'd14,
  parameter logic [5:0] LHU = 6'd15,
  parameter logic [5:0] SB  = 6'd16,
  parameter logic [5:0] SH  = 6'd17,
  parameter logic [5:0] SW  = 6'd18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        en_signal_from_lsb,
  input  logic [5:0]  inst_name_from_lsb,
  input  logic [31:0] mem_addr_from_lsb,
  input  logic [31:0] store_value_from_lsb,
  input  logic [4:0]  rob_id_from_lsb,
  output logic        busy_to_lsb,
  input  logic        rollback_from_rob,
  output logic        en_to_mc,
  output logic        rw_to_mc,
  output logic [31:0] addr_to_mc,
  output logic [2:0]  len_to_mc,
  output logic [31:0] data_to_mc,
  input  logic        done_from_mc,
  input  logic [31:0] data_from_mc,
  output logic        valid_to_cdb,
  output logic [31:0] result_to_cdb,
  output logic [4:0]  rob_id_to_cdb
);

  typedef enum logic {S_IDLE, S_WAIT_MEM} state_t;

  state_t      r_state,  w_state_nxt;
  logic        r_drop,   w_drop_nxt;
  logic        r_busy,   w_busy_nxt;
  logic        r_is_load, w_is_load_nxt;
  logic [5:0]  r_op,     w_op_nxt;
  logic [4:0]  r_rob_id, w_rob_id_nxt;
  logic        r_rw,     w_rw_nxt;
  logic [31:0] r_addr,   w_addr_nxt;
  logic [2:0]  r_len,    w_len_nxt;
  logic [31:0] r_data,   w_data_nxt;
  logic        r_valid,  w_valid_nxt;
  logic [31:0] r_result, w_result_nxt;
  logic [4:0]  r_cdb_id, w_cdb_id_nxt;

  logic        w_req_load, w_req_store;
  logic [2:0]  w_req_len;
  logic [31:0] w_req_data;
  logic [31:0] w_load_ext;

  // Request decode: classify, size and align store data of the incoming op.
  always_comb begin
    w_req_load  = 1'b0;
    w_req_store = 1'b0;
    w_req_len   = 3'd4;
    w_req_data  = 32'h0;
    case (inst_name_from_lsb)
      LB, LBU: begin w_req_load  = 1'b1; w_req_len = 3'd1; end
      LH, LHU: begin w_req_load  = 1'b1; w_req_len = 3'd2; end
      LW:      begin w_req_load  = 1'b1; w_req_len = 3'd4; end
      SB: begin w_req_store = 1'b1; w_req_len = 3'd1; w_req_data = {24'h0, store_value_from_lsb[7:0]}; end
      SH: begin w_req_store = 1'b1; w_req_len = 3'd2; w_req_data = {16'h0, store_value_from_lsb[15:0]}; end
      SW: begin w_req_store = 1'b1; w_req_len = 3'd4; w_req_data = store_value_from_lsb; end
      default: ;
    endcase
  end

  always_comb begin
    case (r_op)
      LB:      w_load_ext = {{24{data_from_mc[7]}}, data_from_mc[7:0]};
      LBU:     w_load_ext = {24'h0, data_from_mc[7:0]};
      LH:      w_load_ext = {{16{data_from_mc[15]}}, data_from_mc[15:0]};
      LHU:     w_load_ext = {16'h0, data_from_mc[15:0]};
      default: w_load_ext = data_from_mc;
    endcase
  end

  // NOTE: every signal gets a hold/default value before the case so no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_drop_nxt    = r_drop;
    w_busy_nxt    = r_busy;
    w_is_load_nxt = r_is_load;
    w_op_nxt      = r_op;
    w_rob_id_nxt  = r_rob_id;
    w_rw_nxt      = r_rw;
    w_addr_nxt    = r_addr;
    w_len_nxt     = r_len;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    w_result_nxt  = r_result;
    w_cdb_id_nxt  = r_cdb_id;
    case (r_state)
      S_IDLE: begin
        // Rollback squashes a same-cycle load request; committed stores still go.
        if (en_signal_from_lsb && (w_req_store || (w_req_load && !rollback_from_rob))) begin
          w_state_nxt   = S_WAIT_MEM;
          w_drop_nxt    = 1'b0;
          w_busy_nxt    = 1'b1;
          w_is_load_nxt = w_req_load;
          w_op_nxt      = inst_name_from_lsb;
          w_rob_id_nxt  = rob_id_from_lsb;
          w_rw_nxt      = w_req_store;
          w_addr_nxt    = mem_addr_from_lsb;
          w_len_nxt     = w_req_len;
          w_data_nxt    = w_req_data;
        end
      end
      S_WAIT_MEM: begin
        if (rollback_from_rob && r_is_load) w_drop_nxt = 1'b1;
        if (done_from_mc) begin
          w_state_nxt = S_IDLE;
          w_drop_nxt  = 1'b0;
          w_busy_nxt  = 1'b0;
          if (r_is_load && !r_drop) begin
            w_valid_nxt  = 1'b1;
            w_result_nxt = w_load_ext;
            w_cdb_id_nxt = r_rob_id;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_drop    <= 1'b0;
      r_busy    <= 1'b0;
      r_is_load <= 1'b0;
      r_op      <= 6'h0;
      r_rob_id  <= 5'h0;
      r_rw      <= 1'b0;
      r_addr    <= 32'h0;
      r_len     <= 3'h0;
      r_data    <= 32'h0;
      r_valid   <= 1'b0;
      r_result  <= 32'h0;
      r_cdb_id  <= 5'h0;
    end else if (rdy_in) begin
      r_state   <= w_state_nxt;
      r_drop    <= w_drop_nxt;
      r_busy    <= w_busy_nxt;
      r_is_load <= w_is_load_nxt;
      r_op      <= w_op_nxt;
      r_rob_id  <= w_rob_id_nxt;
      r_rw      <= w_rw_nxt;
      r_addr    <= w_addr_nxt;
      r_len     <= w_len_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_result  <= w_result_nxt;
      r_cdb_id  <= w_cdb_id_nxt;
    end
  end

  // The memory request is exactly the busy window, so one register drives both.
  assign busy_to_lsb   = r_busy;
  assign en_to_mc      = r_busy;
  assign rw_to_mc      = r_rw;
  assign addr_to_mc    = r_addr;
  assign len_to_mc     = r_len;
  assign data_to_mc    = r_data;
  assign valid_to_cdb  = r_valid;
  assign result_to_cdb = r_result;
  assign rob_id_to_cdb = r_cdb_id;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: loads with extension, stores, rollback, stall and reset.
module tb_lsu;

  localparam logic [5:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14,
                         LHU = 6'd15, SB = 6'd16, SH = 6'd17, SW = 6'd18;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        en_signal_from_lsb;
  logic [5:0]  inst_name_from_lsb;
  logic [31:0] mem_addr_from_lsb, store_value_from_lsb;
  logic [4:0]  rob_id_from_lsb;
  logic        busy_to_lsb, rollback_from_rob;
  logic        en_to_mc, rw_to_mc;
  logic [31:0] addr_to_mc, data_to_mc;
  logic [2:0]  len_to_mc;
  logic        done_from_mc;
  logic [31:0] data_from_mc;
  logic        valid_to_cdb;
  logic [31:0] result_to_cdb;
  logic [4:0]  rob_id_to_cdb;

  int checks = 0;
  int failures = 0;

  lsu dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .en_signal_from_lsb(en_signal_from_lsb), .inst_name_from_lsb(inst_name_from_lsb),
    .mem_addr_from_lsb(mem_addr_from_lsb), .store_value_from_lsb(store_value_from_lsb),
    .rob_id_from_lsb(rob_id_from_lsb), .busy_to_lsb(busy_to_lsb),
    .rollback_from_rob(rollback_from_rob), .en_to_mc(en_to_mc), .rw_to_mc(rw_to_mc),
    .addr_to_mc(addr_to_mc), .len_to_mc(len_to_mc), .data_to_mc(data_to_mc),
    .done_from_mc(done_from_mc), .data_from_mc(data_from_mc),
    .valid_to_cdb(valid_to_cdb), .result_to_cdb(result_to_cdb), .rob_id_to_cdb(rob_id_to_cdb)
  );

  always #5 clk_in = ~clk_in;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] val, input logic [4:0] id, input logic rb);
    en_signal_from_lsb   = 1'b1;
    inst_name_from_lsb   = op;
    mem_addr_from_lsb    = addr;
    store_value_from_lsb = val;
    rob_id_from_lsb      = id;
    rollback_from_rob    = rb;
    tick();
    en_signal_from_lsb = 1'b0;
    rollback_from_rob  = 1'b0;
  endtask

  task automatic complete(input logic [31:0] rdata);
    done_from_mc = 1'b1;
    data_from_mc = rdata;
    tick();
    done_from_mc = 1'b0;
    data_from_mc = 32'h0;
  endtask

  // Concatenation of every output, for reset/freeze comparisons.
  function automatic logic [107:0] all_out();
    return {busy_to_lsb, en_to_mc, rw_to_mc, addr_to_mc, len_to_mc, data_to_mc,
            valid_to_cdb, result_to_cdb, rob_id_to_cdb};
  endfunction

  task automatic test_reset();
    rst_in = 1'b1;
    tick(); tick();
    checks++;
    if (all_out() !== 108'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", all_out());
    end
    rst_in = 1'b0;
    tick();
    checks++;
    if (all_out() !== 108'h0) begin
      failures++; $display("FAIL post_reset_idle got=%h exp=0", all_out());
    end
  endtask

  task automatic test_lb();
    issue(LB, 32'h0000_1000, 32'h0, 5'd3, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({en_to_mc, rw_to_mc, len_to_mc, busy_to_lsb, addr_to_mc, data_to_mc, valid_to_cdb} !==
          {1'b1, 1'b0, 3'd1, 1'b1, 32'h0000_1000, 32'h0, 1'b0}) begin
        failures++;
        $display("FAIL lb_wait cyc=%0d got en=%b rw=%b len=%0d busy=%b addr=%h data=%h valid=%b",
                 c, en_to_mc, rw_to_mc, len_to_mc, busy_to_lsb, addr_to_mc, data_to_mc, valid_to_cdb);
      end
      if (c < 2) tick();
    end
    complete(32'h0000_0080);
    checks++;
    if ({valid_to_cdb, result_to_cdb, rob_id_to_cdb, en_to_mc, busy_to_lsb} !==
        {1'b1, 32'hFFFF_FF80, 5'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL lb_result got valid=%b res=%h id=%0d en=%b busy=%b exp 1 ffffff80 3 0 0",
               valid_to_cdb, result_to_cdb, rob_id_to_cdb, en_to_mc, busy_to_lsb);
    end
    tick();
    checks++;
    if ({valid_to_cdb, result_to_cdb, rob_id_to_cdb} !== {1'b0, 32'hFFFF_FF80, 5'd3}) begin
      failures++;
      $display("FAIL lb_pulse_end got valid=%b res=%h id=%0d exp 0 ffffff80 3",
               valid_to_cdb, result_to_cdb, rob_id_to_cdb);
    end
  endtask

  task automatic test_load_ext();
    logic [5:0]  ops  [4] = '{LBU, LHU, LH, LW};
    logic [2:0]  lens [4] = '{3'd1, 3'd2, 3'd2, 3'd4};
    logic [31:0] exps [4] = '{32'h0000_0080, 32'h0000_F080, 32'hFFFF_F080, 32'h0000_F080};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 32'h0000_4000 + 32'(i * 4), 32'hFFFF_FFFF, 5'(10 + i), 1'b0);
      checks++;
      if ({len_to_mc, data_to_mc, rw_to_mc} !== {lens[i], 32'h0, 1'b0}) begin
        failures++;
        $display("FAIL ext_req_%0d got len=%0d data=%h rw=%b exp len=%0d data=0 rw=0",
                 i, len_to_mc, data_to_mc, rw_to_mc, lens[i]);
      end
      complete(32'h0000_F080);
      checks++;
      if ({valid_to_cdb, result_to_cdb, rob_id_to_cdb} !== {1'b1, exps[i], 5'(10 + i)}) begin
        failures++;
        $display("FAIL ext_result_%0d got valid=%b res=%h id=%0d exp 1 %h %0d",
                 i, valid_to_cdb, result_to_cdb, rob_id_to_cdb, exps[i], 10 + i);
      end
    end
    tick();
  endtask

  task automatic test_store_sh();
    issue(SH, 32'h0000_2002, 32'hDEAD_BEEF, 5'd5, 1'b0);
    checks++;
    if ({en_to_mc, rw_to_mc, len_to_mc, addr_to_mc, data_to_mc} !==
        {1'b1, 1'b1, 3'd2, 32'h0000_2002, 32'h0000_BEEF}) begin
      failures++;
      $display("FAIL sh_req got en=%b rw=%b len=%0d addr=%h data=%h exp 1 1 2 00002002 0000beef",
               en_to_mc, rw_to_mc, len_to_mc, addr_to_mc, data_to_mc);
    end
    tick();
    complete(32'h1234_5678);
    checks++;
    if ({valid_to_cdb, busy_to_lsb, en_to_mc} !== 3'b000) begin
      failures++;
      $display("FAIL sh_done got valid=%b busy=%b en=%b exp 0 0 0", valid_to_cdb, busy_to_lsb, en_to_mc);
    end
  endtask

  task automatic test_rollback_inflight();
    int seen_valid = 0;
    issue(LW, 32'h0000_5000, 32'h0, 5'd7, 1'b0);
    tick();
    rollback_from_rob = 1'b1;
    tick();
    rollback_from_rob = 1'b0;
    if (valid_to_cdb) seen_valid++;
    checks++;
    if ({en_to_mc, busy_to_lsb} !== 2'b11) begin
      failures++; $display("FAIL rb_hold got en=%b busy=%b exp 1 1", en_to_mc, busy_to_lsb);
    end
    tick();
    if (valid_to_cdb) seen_valid++;
    complete(32'hCAFE_F00D);
    if (valid_to_cdb) seen_valid++;
    checks++;
    if ({en_to_mc, busy_to_lsb} !== 2'b00) begin
      failures++; $display("FAIL rb_done got en=%b busy=%b exp 0 0", en_to_mc, busy_to_lsb);
    end
    tick();
    if (valid_to_cdb) seen_valid++;
    checks++;
    if (seen_valid !== 0) begin
      failures++; $display("FAIL rb_no_valid got pulses=%0d exp 0", seen_valid);
    end
  endtask

  task automatic test_rollback_idle();
    issue(LW, 32'h0000_6000, 32'h0, 5'd8, 1'b1);
    checks++;
    if ({busy_to_lsb, en_to_mc} !== 2'b00) begin
      failures++; $display("FAIL rb_idle_lw got busy=%b en=%b exp 0 0", busy_to_lsb, en_to_mc);
    end
    issue(SW, 32'h0000_6004, 32'h89AB_CDEF, 5'd9, 1'b1);
    checks++;
    if ({busy_to_lsb, rw_to_mc, len_to_mc, addr_to_mc, data_to_mc} !==
        {1'b1, 1'b1, 3'd4, 32'h0000_6004, 32'h89AB_CDEF}) begin
      failures++;
      $display("FAIL rb_idle_sw got busy=%b rw=%b len=%0d addr=%h data=%h",
               busy_to_lsb, rw_to_mc, len_to_mc, addr_to_mc, data_to_mc);
    end
    complete(32'h0);
    checks++;
    if ({busy_to_lsb, valid_to_cdb} !== 2'b00) begin
      failures++; $display("FAIL rb_idle_sw_done got busy=%b valid=%b exp 0 0", busy_to_lsb, valid_to_cdb);
    end
  endtask

  task automatic test_stall();
    logic [107:0] snap;
    issue(LH, 32'h0000_3000, 32'h0, 5'd9, 1'b0);
    snap = all_out();
    rdy_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      done_from_mc = (c == 2);
      data_from_mc = 32'h0000_1111;
      tick();
      checks++;
      if (all_out() !== snap) begin
        failures++; $display("FAIL stall_freeze cyc=%0d got=%h exp=%h", c, all_out(), snap);
      end
    end
    done_from_mc = 1'b0;
    rdy_in = 1'b1;
    complete(32'h0000_8001);
    checks++;
    if ({valid_to_cdb, result_to_cdb, rob_id_to_cdb, busy_to_lsb} !== {1'b1, 32'hFFFF_8001, 5'd9, 1'b0}) begin
      failures++;
      $display("FAIL stall_result got valid=%b res=%h id=%0d busy=%b exp 1 ffff8001 9 0",
               valid_to_cdb, result_to_cdb, rob_id_to_cdb, busy_to_lsb);
    end
    rdy_in = 1'b0;
    tick(); tick();
    checks++;
    if (valid_to_cdb !== 1'b1) begin
      failures++; $display("FAIL stall_valid_hold got=%b exp=1", valid_to_cdb);
    end
    rdy_in = 1'b1;
    tick();
    checks++;
    if (valid_to_cdb !== 1'b0) begin
      failures++; $display("FAIL stall_valid_clear got=%b exp=0", valid_to_cdb);
    end
  endtask

  task automatic test_reset_midwait();
    issue(SB, 32'h0000_0010, 32'h1234_56AB, 5'd1, 1'b0);
    checks++;
    if ({en_to_mc, len_to_mc, data_to_mc} !== {1'b1, 3'd1, 32'h0000_00AB}) begin
      failures++; $display("FAIL sb_req got en=%b len=%0d data=%h exp 1 1 000000ab",
                           en_to_mc, len_to_mc, data_to_mc);
    end
    #2 rst_in = 1'b1;
    #1;
    checks++;
    if (all_out() !== 108'h0) begin
      failures++; $display("FAIL async_reset got=%h exp=0", all_out());
    end
    rst_in = 1'b0;
    tick();
    checks++;
    if ({busy_to_lsb, en_to_mc} !== 2'b00) begin
      failures++; $display("FAIL after_async_reset got busy=%b en=%b exp 0 0", busy_to_lsb, en_to_mc);
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    en_signal_from_lsb = 1'b0; inst_name_from_lsb = 6'h0;
    mem_addr_from_lsb = 32'h0; store_value_from_lsb = 32'h0; rob_id_from_lsb = 5'h0;
    rollback_from_rob = 1'b0; done_from_mc = 1'b0; data_from_mc = 32'h0;
    test_reset();
    test_lb();
    test_load_ext();
    test_store_sh();
    test_rollback_inflight();
    test_rollback_idle();
    test_stall();
    test_reset_midwait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the memory-side responder for the load-store buffer's issue port. It accepts one load or store at a time, runs a single byte/half/word transaction with the memory controller, and broadcasts load results with their RoB tag on the common data bus. Loads are sign- or zero-extended here. Stores arrive only after commit and are never cancelled.

## Interface
Parameters (inst_name codes are shared with the dispatcher/LSB encoding):
- LB, default 6'd11, load byte, signed
- LH, default 6'd12, load half, signed
- LW, default 6'd13, load word
- LBU, default 6'd14, load byte, unsigned
- LHU, default 6'd15, load half, unsigned
- SB, default 6'd16, store byte
- SH, default 6'd17, store half
- SW, default 6'd18, store word

Ports:
- clk_in  input  1  clock; all state changes on the rising edge
- rst_in  input  1  reset; one clock; reset is asynchronous and active-high
- rdy_in  input  1  global enable; low freezes all state
- en_signal_from_lsb  input  1  request valid
- inst_name_from_lsb  input  6  operation code
- mem_addr_from_lsb  input  32  byte address
- store_value_from_lsb  input  32  store data; low bytes are used
- rob_id_from_lsb  input  5  destination tag
- busy_to_lsb  output  1  unit occupied
- rollback_from_rob  input  1  flush of speculative state
- en_to_mc  output  1  memory request
- rw_to_mc  output  1  0 = read, 1 = write
- addr_to_mc  output  32  byte address
- len_to_mc  output  3  byte count: 1, 2 or 4
- data_to_mc  output  32  write data; unused bytes are 0
- done_from_mc  input  1  transaction complete; one-cycle pulse
- data_from_mc  input  32  read data, right-aligned
- valid_to_cdb  output  1  load result valid; one-cycle pulse
- result_to_cdb  output  32  extended load value
- rob_id_to_cdb  output  5  tag of the result

## Operation
- States: IDLE and WAIT_MEM. A 1-bit `drop` flag and the latched operation, tag and load flag are kept.
- IDLE with en_signal_from_lsb = 1:
  - Latch the request.
  - Drive en_to_mc = 1 and the rw/addr/len/data fields.
  - Set busy_to_lsb = 1 and go to WAIT_MEM.
- Field mapping:
  - B ops: len = 1; H ops: len = 2; W ops: len = 4.
  - SB writes data_to_mc = {24'b0, v[7:0]}; SH writes {16'b0, v[15:0]}; SW writes v.
  - Loads drive data_to_mc = 0.
- A request while busy_to_lsb = 1 is ignored; holding it off is the LSB's duty. An unknown inst_name in IDLE is ignored, and the unit stays IDLE.
- WAIT_MEM: en_to_mc and all mc fields are held stable until done_from_mc.
- On done_from_mc in WAIT_MEM:
  - Clear en_to_mc and busy_to_lsb, clear `drop`, return to IDLE.
  - If the operation is a load with drop = 0: set valid_to_cdb = 1, set rob_id_to_cdb, and set result_to_cdb:
    - LB: sign-extend bits [7:0]; LBU: zero-extend [7:0].
    - LH: sign-extend [15:0]; LHU: zero-extend [15:0].
    - LW: data as-is.
  - For stores or dropped loads, valid_to_cdb stays 0.
- valid_to_cdb is cleared on every enabled cycle that is not a completing load. result_to_cdb and rob_id_to_cdb hold their last value.
- rollback_from_rob = 1 (enabled cycle):
  - In WAIT_MEM with a load: set drop = 1. The memory transaction still runs to done, and the result is discarded.
  - In WAIT_MEM with a store: no effect.
  - In IDLE with a load request the same cycle: the request is not accepted.
  - In IDLE with a store request the same cycle: the request is accepted normally.
  - It clears valid_to_cdb at the next edge if that edge is not a completing, non-dropped load.
- There is no misalignment check; addresses pass through unchanged.
- rdy_in = 0: no state or output changes, and done_from_mc is ignored. The memory controller shares rdy_in and does not pulse done while it is low.

## Timing
- Reset values: all outputs are 0 (busy_to_lsb, en_to_mc, rw_to_mc, addr_to_mc, len_to_mc, data_to_mc, valid_to_cdb, result_to_cdb, rob_id_to_cdb). State is IDLE and drop = 0.
- Reset mid-transaction abandons the transaction immediately and drops en_to_mc asynchronously.
- Request sampled at edge N: en_to_mc and busy_to_lsb are high after N.
- done sampled at edge M: after M, valid_to_cdb = 1 for exactly one cycle, and en_to_mc and busy_to_lsb are low.
- The next request can be accepted at edge M+1. The minimum initiation interval is mc latency + 1 cycle.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- LB at addr 0x1000, rob_id 3; mc returns 0x00000080 after 3 cycles:
  - during wait: en_to_mc = 1, rw = 0, len = 1, busy = 1.
  - then valid_to_cdb pulses one cycle with result 0xFFFFFF80 and rob_id 3.
- LBU and LHU reading 0x0000F080 -> results 0x00000080 and 0x0000F080. Same data for LH -> 0xFFFFF080.
- SH at 0x2002 with value 0xDEADBEEF -> rw = 1, len = 2, data_to_mc = 0x0000BEEF. No valid_to_cdb pulse; busy drops after done.
- LW in flight, rollback pulsed two cycles before done -> en_to_mc stays high until done, and valid_to_cdb is never asserted.
- In IDLE, a rollback coinciding with a request:
  - LW request -> not accepted; busy stays 0.
  - SW request -> accepted; the write completes.
- rdy_in low for 4 cycles mid-WAIT_MEM, then done -> outputs frozen during the stall. Asserting rst_in mid-wait -> every output is 0 without a clock edge.
